// File: rtl/iter_alu_if.sv
// Request/response bundle for iter_alu: valid/ready request side, valid/ready result side.
interface iter_alu_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             zero;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, res, zero
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, res, zero
  );
endinterface

// File: rtl/iter_alu.sv
// Handshaked integer execution unit: single-cycle ALU ops plus iterative
// shift-add multiply and restoring divide on operand magnitudes.
module iter_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst_n,
  iter_alu_if.slave alu_io
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [4:0] OpAdd  = 5'd0;
  localparam logic [4:0] OpSub  = 5'd1;
  localparam logic [4:0] OpAnd  = 5'd2;
  localparam logic [4:0] OpOr   = 5'd3;
  localparam logic [4:0] OpXor  = 5'd4;
  localparam logic [4:0] OpSll  = 5'd5;
  localparam logic [4:0] OpSrl  = 5'd6;
  localparam logic [4:0] OpSra  = 5'd7;
  localparam logic [4:0] OpSlt  = 5'd8;
  localparam logic [4:0] OpSltu = 5'd9;

  state_e           state_q;
  logic             in_ready_q, out_valid_q, zero_q, neg_q;
  logic [WIDTH-1:0] res_q, hi_q, lo_q, addend_q;
  logic [SHW-1:0]   cnt_q;
  logic [2:0]       op_q;

  logic [WIDTH-1:0] a_in, b_in;
  logic [4:0]       op_in;
  logic [SHW-1:0]   shamt;

  assign a_in  = alu_io.a;
  assign b_in  = alu_io.b;
  assign op_in = alu_io.op;
  assign shamt = b_in[SHW-1:0];

  logic [WIDTH-1:0] fast_res, idle_res, mag_a, mag_b;
  logic             is_iter, is_div, is_rem, a_sgn, b_sgn, a_neg, b_neg;
  logic             div_zero, div_ovf, take_fast, neg_in;

  // Decode the incoming request: single-cycle result, special cases, operand magnitudes.
  always_comb begin
    fast_res = '0;
    case (op_in)
      OpAdd:   fast_res = a_in + b_in;
      OpSub:   fast_res = a_in - b_in;
      OpAnd:   fast_res = a_in & b_in;
      OpOr:    fast_res = a_in | b_in;
      OpXor:   fast_res = a_in ^ b_in;
      OpSll:   fast_res = a_in << shamt;
      OpSrl:   fast_res = a_in >> shamt;
      OpSra:   fast_res = $signed(a_in) >>> shamt;
      OpSlt:   fast_res = {{(WIDTH-1){1'b0}}, $signed(a_in) < $signed(b_in)};
      OpSltu:  fast_res = {{(WIDTH-1){1'b0}}, a_in < b_in};
      default: fast_res = '0;
    endcase

    is_iter = (op_in[4:3] == 2'b10);
    is_div  = is_iter && op_in[2];
    is_rem  = is_div && op_in[1];
    // Multiply: MULHU unsigned a; MULHSU/MULHU unsigned b. Divide: odd codes unsigned.
    a_sgn   = is_div ? ~op_in[0] : (op_in[1:0] != 2'b11);
    b_sgn   = is_div ? ~op_in[0] : ~op_in[1];
    a_neg   = a_sgn && a_in[WIDTH-1];
    b_neg   = b_sgn && b_in[WIDTH-1];
    mag_a   = a_neg ? ('0 - a_in) : a_in;
    mag_b   = b_neg ? ('0 - b_in) : b_in;
    // Remainder follows the dividend's sign; quotient and product follow the XOR.
    neg_in  = is_rem ? a_neg : (a_neg ^ b_neg);

    div_zero  = is_div && (b_in == '0);
    div_ovf   = is_div && !op_in[0] && (a_in == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_in);
    take_fast = !is_iter || div_zero || div_ovf;

    if (div_zero) begin
      idle_res = is_rem ? a_in : '1;
    end else if (div_ovf) begin
      idle_res = is_rem ? '0 : a_in;
    end else begin
      idle_res = fast_res;
    end
  end

  logic [WIDTH:0]     mul_sum, div_sh, div_trial;
  logic [WIDTH-1:0]   step_hi, step_lo, q_fix, r_fix, fin_res;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // One iteration step and the sign fix-up applied on the final step.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, addend_q} : '0);
    div_sh    = {hi_q, lo_q[WIDTH-1]};
    div_trial = div_sh - {1'b0, addend_q};
    step_hi   = '0;
    step_lo   = '0;
    if (op_q[2]) begin
      // Restoring divide: remainder in hi, quotient bits shift into lo.
      if (!div_trial[WIDTH]) begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_sh[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Shift-add multiply: multiplier consumed from lo, product grows into hi.
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? ('0 - prod) : prod;
    q_fix    = neg_q ? ('0 - step_lo) : step_lo;
    r_fix    = neg_q ? ('0 - step_hi) : step_hi;
    case (op_q)
      3'd0:                fin_res = prod_fix[WIDTH-1:0];
      3'd1, 3'd2, 3'd3:    fin_res = prod_fix[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:          fin_res = q_fix;
      default:             fin_res = r_fix;
    endcase
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b1;
      cnt_q       <= '0;
      op_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      addend_q    <= '0;
      neg_q       <= 1'b0;
    end else if (alu_io.flush) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (alu_io.in_valid) begin
            op_q       <= op_in[2:0];
            in_ready_q <= 1'b0;
            if (take_fast) begin
              res_q       <= idle_res;
              zero_q      <= (idle_res == '0);
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              hi_q     <= '0;
              lo_q     <= is_div ? mag_a : mag_b;
              addend_q <= is_div ? mag_b : mag_a;
              neg_q    <= neg_in;
              cnt_q    <= '0;
              state_q  <= StBusy;
            end
          end
        end
        StBusy: begin
          hi_q <= step_hi;
          lo_q <= step_lo;
          if (cnt_q == SHW'(WIDTH - 1)) begin
            res_q       <= fin_res;
            zero_q      <= (fin_res == '0);
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + SHW'(1);
          end
        end
        StDone: begin
          if (alu_io.out_ready) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu_io.in_ready  = in_ready_q;
  assign alu_io.out_valid = out_valid_q;
  assign alu_io.res       = res_q;
  assign alu_io.zero      = zero_q;

endmodule

// File: tb/tb_iter_alu.sv
// Bench for iter_alu: directed corner cases, flush/reset aborts, then random ops
// checked against an arithmetic reference model.
module tb_iter_alu;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  iter_alu_if #(.WIDTH(W)) bus ();

  iter_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .alu_io (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result computed with wide signed/unsigned arithmetic.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] ua64, ub64, pu;
    logic [31:0] r;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub   = longint'({32'b0, b});
    ua64 = {32'b0, a};
    ub64 = {32'b0, b};
    r    = 32'b0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = a << b[4:0];
      5'd6:  r = a >> b[4:0];
      5'd7:  begin p = sa >>> b[4:0]; r = p[31:0]; end
      5'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd9:  r = (a < b) ? 32'd1 : 32'd0;
      5'd16: begin p = sa * sb; r = p[31:0]; end
      5'd17: begin p = sa * sb; r = p[63:32]; end
      5'd18: begin p = sa * ub; r = p[63:32]; end
      5'd19: begin pu = ua64 * ub64; r = pu[63:32]; end
      5'd20: if (b == 0) r = 32'hFFFF_FFFF; else begin p = sa / sb; r = p[31:0]; end
      5'd21: if (b == 0) r = 32'hFFFF_FFFF; else r = a / b;
      5'd22: if (b == 0) r = a; else begin p = sa % sb; r = p[31:0]; end
      5'd23: if (b == 0) r = a; else r = a % b;
      default: r = 32'b0;
    endcase
    return r;
  endfunction

  // Edges from acceptance (counted as 1) until out_valid is seen.
  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op >= 5'd16 && op <= 5'd23) begin
      if (op >= 5'd20 && b == 0) return 1;
      if ((op == 5'd20 || op == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return 1;
  endfunction

  task automatic accept(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op       = 5'($urandom);
    bus.a        = $urandom;
    bus.b        = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int hold);
    int          lat, unstable, el;
    logic        rdy_seen;
    logic [31:0] held;
    el = exp_lat(op, a, b);
    accept(op, a, b);
    lat      = 1;
    rdy_seen = 1'b0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      rdy_seen |= bus.in_ready;
      @(posedge clk); #1;
      lat++;
    end
    rdy_seen |= bus.in_ready;
    check({tag, "_lat"}, 32'(lat), 32'(el));
    check({tag, "_res"}, bus.res, exp_r);
    check({tag, "_zero"}, {31'b0, bus.zero}, {31'b0, exp_r == 0});
    check({tag, "_in_ready_low"}, {31'b0, rdy_seen}, 32'd0);
    held     = bus.res;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (bus.res !== held || bus.out_valid !== 1'b1) unstable++;
    end
    if (hold > 0) check({tag, "_hold"}, 32'(unstable), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_ov_drop"}, {31'b0, bus.out_valid}, 32'd0);
    check({tag, "_rdy_back"}, {31'b0, bus.in_ready}, 32'd1);
  endtask

  // Watch for a spurious out_valid over a window of cycles.
  task automatic quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      seen |= bus.out_valid;
    end
    check(tag, {31'b0, seen}, 32'd0);
  endtask

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    bus.in_valid  = 1'b0;
    bus.op        = 5'd0;
    bus.a         = '0;
    bus.b         = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_res", bus.res, 32'd0);
    check("rst_zero", {31'b0, bus.zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add", 5'd0, 32'd31, 32'd31, 32'd62, 0);
    run_op("sub", 5'd1, 32'd31, 32'd31, 32'd0, 0);
    run_op("sra", 5'd7, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
    run_op("slt", 5'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
    run_op("sltu", 5'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    run_op("unlisted", 5'd12, 32'h1234, 32'h5678, 32'd0, 0);
    run_op("mul", 5'd16, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5);
    run_op("mulh", 5'd17, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run_op("mulhu", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div", 5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("rem", 5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("divu_z", 5'd21, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("remu_z", 5'd23, 32'd5, 32'd0, 32'd5, 0);
    run_op("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

    // Flush in BUSY: abort, never complete.
    accept(5'd16, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy_ov", {31'b0, bus.out_valid}, 32'd0);
    check("flush_busy_rdy", {31'b0, bus.in_ready}, 32'd1);
    quiet("flush_busy_quiet", 40);
    run_op("add_after_flush", 5'd0, 32'd5, 32'd6, 32'd11, 0);

    // Request coincident with flush in IDLE is dropped.
    @(negedge clk);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = 5'd0;
    bus.a        = 32'd1;
    bus.b        = 32'd2;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_idle_rdy", {31'b0, bus.in_ready}, 32'd1);
    quiet("flush_idle_quiet", 3);

    // Flush in DONE beats the out_ready handshake.
    accept(5'd0, 32'd3, 32'd4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    check("flush_done_ov", {31'b0, bus.out_valid}, 32'd0);
    check("flush_done_rdy", {31'b0, bus.in_ready}, 32'd1);

    // Asynchronous reset in BUSY.
    accept(5'd21, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ov", {31'b0, bus.out_valid}, 32'd0);
    check("arst_rdy", {31'b0, bus.in_ready}, 32'd1);
    check("arst_res", bus.res, 32'd0);
    check("arst_zero", {31'b0, bus.zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    quiet("arst_quiet", 40);
    run_op("add_after_rst", 5'd0, 32'd100, 32'd23, 32'd123, 0);

    // Random ops against the reference model.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1) rop = 5'(16 + $urandom_range(0, 7));
      else rop = 5'($urandom_range(0, 31));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      run_op("rnd", rop, ra, rb, model(rop, ra, rb), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iter_alu.md
# iter_alu

Parametrised, handshaked RV32IM-class execution unit. Performs single-cycle integer ops and iterative multiply/divide/remainder on WIDTH-bit operands behind a valid/ready interface. Sits in the EX stage beside the existing combinational ALU. The pipeline stalls on `in_ready`/`out_valid` instead of assuming fixed latency.

## Interface
- `WIDTH`, 32: operand/result width; power of two, ≥ 8.
- `SHW`, $clog2(WIDTH): derived shift-amount width; not to be overridden.

- `clk` in 1: rising-edge clock, the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit can accept a request.
- `op` in 5: operation code (see Operation).
- `a` in WIDTH: operand A (rs1).
- `b` in WIDTH: operand B (rs2/imm).
- `flush` in 1: synchronous abort of any in-flight or held operation.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer takes result.
- `res` out WIDTH: result, registered.
- `zero` out 1: `res == 0`, registered with `res`.

## Operation
- Opcodes, 1-cycle class:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount = `b[SHW-1:0]`.
  - 8 SLT (signed, result 0/1), 9 SLTU.
  - Any unlisted code gives `res = 0`, 1-cycle class.
- Opcodes, iterative class:
  - 16 MUL (low WIDTH bits), 17 MULH (s×s high), 18 MULHSU (s×u high), 19 MULHU (u×u high).
  - 20 DIV, 21 DIVU, 22 REM, 23 REMU.
- FSM states:
  - IDLE: `in_ready=1`. `in_valid` captures `op`, `a`, `b`.
    - 1-cycle op, div-by-zero or signed overflow: compute and go to DONE.
    - Otherwise clear `cnt` and go to BUSY.
  - BUSY: one iteration per cycle, `cnt` increments. After WIDTH iterations, write `res` and go to DONE.
  - DONE: `out_valid=1`, `res`/`zero` held stable. `out_ready` returns to IDLE.
- `in_ready` is 0 in BUSY and DONE. There is no overlap of requests.
- Multiply:
  - Shift-add on magnitudes over a 2·WIDTH product register.
  - Sign fix-up at completion per operand signedness.
  - MULHSU treats `b` as unsigned.
- Divide: restoring, on magnitudes.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a); signed ops only.
- Special cases, resolved in IDLE (1-cycle class):
  - `b == 0`: DIV/DIVU give all-ones; REM/REMU give `a`.
  - DIV with `a` = most-negative and `b` = all-ones gives `a`; REM gives 0.
- `flush`: from any state, go to IDLE next cycle with `out_valid=0`. A request presented in the same cycle as `flush` is not accepted.

## Timing
- Reset values: state IDLE, `in_ready=1`, `out_valid=0`, `res=0`, `zero=1`, `cnt=0`, internal regs 0.
- `rst_n` low mid-BUSY or mid-DONE aborts immediately (asynchronous). No result is produced.
- Acceptance occurs on the edge where `in_valid && in_ready`.
- 1-cycle class: `out_valid` rises on the edge after acceptance, so latency is 1.
- Iterative class: `out_valid` rises WIDTH+1 edges after acceptance (33 for WIDTH=32).
- `out_valid && out_ready` in DONE: `out_valid` falls and `in_ready` rises on the next edge. Minimum issue interval is 2 cycles for the 1-cycle class.
- `out_ready` may be held low indefinitely; `res` must not change while `out_valid=1`.
- Operand changes after acceptance have no effect.
- `flush` takes priority over the `out_ready` handshake in the same cycle.

## Test plan
- Reset, then ADD a=31, b=31 → next cycle `out_valid=1`, `res=62`, `zero=0`. Then SUB 31,31 → `res=0`, `zero=1`.
- SRA a=0x80000000, b=0x24 (shamt 4) → `res=0xF8000000`. SLT a=0xFFFFFFFF, b=1 → 1. SLTU same operands → 0.
- MUL 7×0xFFFFFFFD → `res=0xFFFFFFEB` on the 33rd edge after acceptance, with `in_ready=0` throughout.
- MULH 0x80000000×0x80000000 → `0x40000000`. MULHU 0xFFFFFFFF×0xFFFFFFFF → `0xFFFFFFFE`.
- DIV −7/2 → `0xFFFFFFFD`; REM −7/2 → `0xFFFFFFFF`. DIVU 5/0 → `0xFFFFFFFF` after 1 cycle; REMU 5/0 → 5. DIV 0x80000000/−1 → `0x80000000`; REM → 0.
- Backpressure: `out_ready` low for 5 cycles after `out_valid`, so `res` is held stable. Also assert `flush` at BUSY cycle 10 and, separately, `rst_n` low at BUSY cycle 10 → IDLE, `out_valid` never rises, and the next ADD completes correctly.
